// File: rtl/imem_loader.sv
// imem_loader: writer side of the instruction memory.
// Takes a length-prefixed program image as a byte stream over valid/ready,
// packs four bytes at a time into little-endian 32-bit words and issues one
// single-cycle write per word. busy holds the core off until the whole image
// is in memory. ADDR_W is expected to be in the range 1..16, since the
// header carries a 16-bit word count.

module imem_loader #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              we,
    output logic [31:0]       wa,
    output logic [31:0]       wd,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   word_count
);

    // Memory capacity in words, wide enough to hold 2**16.
    localparam logic [16:0] DEPTH_C = 17'd1 << ADDR_W;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_LO = 3'd1,
        ST_LEN_HI = 3'd2,
        ST_DATA   = 3'd3,
        ST_DONE   = 3'd4,
        ST_ERROR  = 3'd5
    } state_t;

    state_t            state_r;
    logic              in_ready_r;
    logic              we_r;
    logic [31:0]       wa_r;
    logic [31:0]       wd_r;
    logic              busy_r;
    logic              done_r;
    logic              err_r;
    logic [ADDR_W:0]   word_count_r;

    logic [7:0]        len_lo_r;     // low header byte, held until the high byte arrives
    logic [15:0]       len_r;        // image length in words for the current load
    logic [1:0]        byte_idx_r;   // lane that the next data byte fills
    logic [ADDR_W-1:0] word_idx_r;   // word address of the word being assembled
    logic [23:0]       asm_r;        // lanes 0..2 of the word being assembled
    logic              last_pend_r;  // final word is being written this cycle

    logic              hs_s;
    logic [15:0]       hdr_len_s;
    logic              len_bad_s;
    logic              last_word_s;

    // Byte acceptance qualifier plus header and final-word decodes.
    always_comb begin
        hs_s        = 1'b0;
        hdr_len_s   = {in_data, len_lo_r};
        len_bad_s   = 1'b0;
        last_word_s = 1'b0;

        // While the final word is being written the image is complete, so any
        // byte offered in that cycle is not part of it and is dropped.
        if (in_valid && in_ready_r && !last_pend_r) begin
            hs_s = 1'b1;
        end else begin
            hs_s = 1'b0;
        end

        // A zero-length image or one larger than the memory is rejected.
        if ((hdr_len_s == 16'd0) || ({1'b0, hdr_len_s} > DEPTH_C)) begin
            len_bad_s = 1'b1;
        end else begin
            len_bad_s = 1'b0;
        end

        if (16'(word_idx_r) == (len_r - 16'd1)) begin
            last_word_s = 1'b1;
        end else begin
            last_word_s = 1'b0;
        end
    end

    // Load sequencer: header parsing, word assembly, write issue and status.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            in_ready_r   <= 1'b0;
            we_r         <= 1'b0;
            wa_r         <= 32'd0;
            wd_r         <= 32'd0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            err_r        <= 1'b0;
            word_count_r <= '0;
            len_lo_r     <= 8'd0;
            len_r        <= 16'd0;
            byte_idx_r   <= 2'd0;
            word_idx_r   <= '0;
            asm_r        <= 24'd0;
            last_pend_r  <= 1'b0;
        end else begin
            // The write strobe is a one-cycle pulse unless re-armed below.
            we_r <= 1'b0;

            case (state_r)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (start) begin
                        state_r    <= ST_LEN_LO;
                        in_ready_r <= 1'b1;
                        busy_r     <= 1'b1;
                        done_r     <= 1'b0;
                        err_r      <= 1'b0;
                    end else begin
                        state_r    <= state_r;
                    end
                end

                ST_LEN_LO: begin
                    if (hs_s) begin
                        len_lo_r <= in_data;
                        state_r  <= ST_LEN_HI;
                    end else begin
                        state_r  <= ST_LEN_LO;
                    end
                end

                ST_LEN_HI: begin
                    if (hs_s) begin
                        if (len_bad_s) begin
                            state_r    <= ST_ERROR;
                            err_r      <= 1'b1;
                            busy_r     <= 1'b0;
                            in_ready_r <= 1'b0;
                        end else begin
                            state_r      <= ST_DATA;
                            len_r        <= hdr_len_s;
                            byte_idx_r   <= 2'd0;
                            word_idx_r   <= '0;
                            word_count_r <= '0;
                            last_pend_r  <= 1'b0;
                        end
                    end else begin
                        state_r <= ST_LEN_HI;
                    end
                end

                ST_DATA: begin
                    if (last_pend_r) begin
                        // Final write is on the bus this cycle; finish next.
                        state_r     <= ST_DONE;
                        done_r      <= 1'b1;
                        busy_r      <= 1'b0;
                        in_ready_r  <= 1'b0;
                        last_pend_r <= 1'b0;
                    end else if (hs_s) begin
                        byte_idx_r <= byte_idx_r + 2'd1;
                        case (byte_idx_r)
                            2'd0: asm_r[7:0]   <= in_data;
                            2'd1: asm_r[15:8]  <= in_data;
                            2'd2: asm_r[23:16] <= in_data;
                            2'd3: begin
                                we_r         <= 1'b1;
                                wa_r         <= 32'({word_idx_r, 2'b00});
                                wd_r         <= {in_data, asm_r};
                                word_count_r <= word_count_r + (ADDR_W+1)'(1'b1);
                                // Word index saturates at N-1 so it can never
                                // point past the image or wrap the memory.
                                if (last_word_s) begin
                                    last_pend_r <= 1'b1;
                                    word_idx_r  <= word_idx_r;
                                end else begin
                                    last_pend_r <= 1'b0;
                                    word_idx_r  <= word_idx_r + ADDR_W'(1'b1);
                                end
                            end
                            default: asm_r <= asm_r;
                        endcase
                    end else begin
                        state_r <= ST_DATA;
                    end
                end

                default: begin
                    state_r    <= ST_IDLE;
                    in_ready_r <= 1'b0;
                    busy_r     <= 1'b0;
                    done_r     <= 1'b0;
                    err_r      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready   = in_ready_r;
    assign we         = we_r;
    assign wa         = wa_r;
    assign wd         = wd_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign err        = err_r;
    assign word_count = word_count_r;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: a cycle table for the handshake/status timing, then
// whole-image loads compared against a reference built straight from the
// stream format (header length, 4 little-endian bytes per word, wa = 4*i).

module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        we;
    logic [31:0] wa;
    logic [31:0] wd;
    logic        busy;
    logic        done;
    logic        err;
    logic [8:0]  word_count;

    int n_check = 0;
    int n_pass  = 0;
    int rdy_viol = 0;
    logic [63:0] wr_q[$];

    imem_loader #(.ADDR_W(8)) dut (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
        .in_data(in_data), .in_ready(in_ready), .we(we), .wa(wa), .wd(wd),
        .busy(busy), .done(done), .err(err), .word_count(word_count)
    );

    always #5 clk = ~clk;

    // Record every write and watch that in_ready tracks busy.
    always @(negedge clk) begin
        if (we === 1'b1) wr_q.push_back({wa, wd});
        if (busy !== in_ready) rdy_viol++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_check++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Offer cnt bytes of s, with optional random idle gaps and a start pulse
    // alongside byte start_at. Returns at the negedge after the last transfer.
    task automatic send_bytes(input logic [7:0] s[$], input int cnt, input int max_gap,
                              input int start_at);
        for (int i = 0; i < cnt; i++) begin
            int gap;
            int t;
            gap = (max_gap > 0) ? $urandom_range(0, max_gap) : 0;
            in_valid = 1'b0;
            repeat (gap) @(negedge clk);
            in_valid = 1'b1;
            in_data  = s[i];
            if (i == start_at) start = 1'b1;
            t = 0;
            while (in_ready !== 1'b1 && t < 50) begin
                @(negedge clk);
                t++;
            end
            if (in_ready !== 1'b1) begin
                n_check++;
                $display("FAIL hs_timeout: byte %0d not accepted, in_ready=%b", i, in_ready);
                in_valid = 1'b0;
                start = 1'b0;
                return;
            end
            @(posedge clk);
            @(negedge clk);
            start    = 1'b0;
            in_valid = 1'b0;
        end
    endtask

    // Build a random image of n words with a correct header.
    task automatic make_img(input int n, output logic [7:0] q[$]);
        q = {};
        q.push_back(n[7:0]);
        q.push_back(n[15:8]);
        for (int i = 0; i < 4 * n; i++) q.push_back(8'($urandom));
    endtask

    // Start a load, stream s, and compare against the stream-format reference.
    task automatic run_load(input string tag, input logic [7:0] s[$], input int max_gap,
                            input int start_at);
        int n;
        wr_q.delete();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({tag, "_start_busy"}, busy, 1'b1);
        chk({tag, "_start_rdy"}, in_ready, 1'b1);
        send_bytes(s, s.size(), max_gap, start_at);
        n = {s[1], s[0]};
        if (n == 0 || n > 256) begin
            chk({tag, "_err"}, err, 1'b1);
            chk({tag, "_err_rdy"}, in_ready, 1'b0);
            chk({tag, "_err_busy"}, busy, 1'b0);
            repeat (5) @(negedge clk);
            chk({tag, "_err_nowe"}, wr_q.size(), 0);
            chk({tag, "_err_sticky"}, err, 1'b1);
        end else begin
            chk({tag, "_last_we"}, we, 1'b1);
            chk({tag, "_last_busy"}, busy, 1'b1);
            @(negedge clk);
            chk({tag, "_done"}, done, 1'b1);
            chk({tag, "_done_busy"}, busy, 1'b0);
            chk({tag, "_done_rdy"}, in_ready, 1'b0);
            chk({tag, "_no_err"}, err, 1'b0);
            chk({tag, "_wc"}, word_count, 64'(n));
            chk({tag, "_nwrites"}, wr_q.size(), 64'(n));
            for (int i = 0; i < n && i < wr_q.size(); i++) begin
                int j;
                logic [31:0] ew;
                j  = 2 + 4 * i;
                ew = {s[j + 3], s[j + 2], s[j + 1], s[j]};
                chk($sformatf("%s_w%0d", tag, i), wr_q[i], {32'(4 * i), ew});
            end
        end
    endtask

    typedef struct {
        logic        st;
        logic        vld;
        logic [7:0]  dat;
        logic        rdy;
        logic        we;
        logic [31:0] wa;
        logic [31:0] wd;
        logic        busy;
        logic        done;
        logic        err;
        logic [8:0]  wc;
    } vec_t;

    vec_t tbl[16];
    logic [7:0] nom[$];
    logic [7:0] q[$];

    initial begin
        // Row: inputs driven after checking the expected outputs of that cycle.
        //          st    vld   dat    rdy   we    wa     wd          busy  done  err   wc
        tbl[0]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 32'h0, 32'h0,      1'b0, 1'b0, 1'b0, 9'd0};
        tbl[1]  = '{1'b0, 1'b1, 8'h01, 1'b1, 1'b0, 32'h0, 32'h0,      1'b1, 1'b0, 1'b0, 9'd0};
        tbl[2]  = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 32'h0, 32'h0,      1'b1, 1'b0, 1'b0, 9'd0};
        tbl[3]  = '{1'b0, 1'b1, 8'h02, 1'b1, 1'b0, 32'h0, 32'h0,      1'b1, 1'b0, 1'b0, 9'd0};
        tbl[4]  = '{1'b0, 1'b0, 8'hff, 1'b1, 1'b0, 32'h0, 32'h0,      1'b1, 1'b0, 1'b0, 9'd0};
        tbl[5]  = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 32'h0, 32'h0,      1'b1, 1'b0, 1'b0, 9'd0};
        tbl[6]  = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 32'h0, 32'h0,      1'b1, 1'b0, 1'b0, 9'd0};
        tbl[7]  = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 32'h0, 32'h0,      1'b1, 1'b0, 1'b0, 9'd0};
        tbl[8]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 32'h0, 32'h2,      1'b1, 1'b0, 1'b0, 9'd1};
        tbl[9]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 32'h0, 32'h2,      1'b0, 1'b1, 1'b0, 9'd1};
        tbl[10] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 32'h0, 32'h2,      1'b0, 1'b1, 1'b0, 9'd1};
        tbl[11] = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 32'h0, 32'h2,      1'b1, 1'b0, 1'b0, 9'd1};
        tbl[12] = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 32'h0, 32'h2,      1'b1, 1'b0, 1'b0, 9'd1};
        tbl[13] = '{1'b0, 1'b1, 8'h55, 1'b0, 1'b0, 32'h0, 32'h2,      1'b0, 1'b0, 1'b1, 9'd1};
        tbl[14] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 32'h0, 32'h2,      1'b0, 1'b0, 1'b1, 9'd1};
        tbl[15] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 32'h0, 32'h2,      1'b1, 1'b0, 1'b0, 9'd1};

        nom = '{8'h07, 8'h00,
                8'h93, 8'h00, 8'h30, 8'h0f,  8'h13, 8'h01, 8'h90, 8'h00,
                8'h33, 8'h81, 8'h20, 8'h00,  8'hb3, 8'hf1, 8'h20, 8'h00,
                8'h33, 8'he2, 8'h20, 8'h00,  8'h33, 8'ha3, 8'h41, 8'h00,
                8'hb3, 8'h03, 8'h62, 8'h40};

        reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        repeat (2) @(negedge clk);
        chk("rst_rdy", in_ready, 1'b0);
        chk("rst_we", we, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_flags", {done, err, word_count, wa, wd}, 64'h0);
        reset = 1'b0;

        // Cycle-accurate table: 1-word load, start in DONE, zero-length header.
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            chk($sformatf("tbl%0d_rdy", i),  in_ready,   tbl[i].rdy);
            chk($sformatf("tbl%0d_we", i),   we,         tbl[i].we);
            chk($sformatf("tbl%0d_wa", i),   wa,         tbl[i].wa);
            chk($sformatf("tbl%0d_wd", i),   wd,         tbl[i].wd);
            chk($sformatf("tbl%0d_busy", i), busy,       tbl[i].busy);
            chk($sformatf("tbl%0d_done", i), done,       tbl[i].done);
            chk($sformatf("tbl%0d_err", i),  err,        tbl[i].err);
            chk($sformatf("tbl%0d_wc", i),   word_count, tbl[i].wc);
            start    = tbl[i].st;
            in_valid = tbl[i].vld;
            in_data  = tbl[i].dat;
        end
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;

        // Nominal image at full rate, with the listed words checked literally.
        run_load("nom", nom, 0, -1);
        if (wr_q.size() == 7) begin
            chk("nom_w0_lit", wr_q[0], {32'h00, 32'h0f300093});
            chk("nom_w3_lit", wr_q[3], {32'h0c, 32'h0020f1b3});
            chk("nom_w6_lit", wr_q[6], {32'h18, 32'h406203b3});
        end else begin
            chk("nom_count_lit", wr_q.size(), 7);
        end

        // Same image with random gaps; then a start pulse in the middle of DATA.
        for (int k = 0; k < 3; k++) run_load($sformatf("gap%0d", k), nom, 5, -1);
        run_load("start_in_data", nom, 0, 13);

        // Rejected headers, then recovery with a 1-word image.
        q = '{8'h00, 8'h00};
        run_load("hdr0", q, 0, -1);
        q = '{8'h01, 8'h01};
        run_load("hdr257", q, 0, -1);
        q = '{8'h01, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00};
        run_load("recover", q, 0, -1);

        // Random images, random gaps, random stray start inside DATA.
        for (int k = 0; k < 4; k++) begin
            make_img($urandom_range(1, 6), q);
            run_load($sformatf("rnd%0d", k), q, 3, $urandom_range(4, q.size() - 1));
        end

        // Full-capacity image: last write must land at (DEPTH-1)*4.
        make_img(256, q);
        run_load("full", q, 0, -1);

        // Asynchronous reset partway through the third of three words.
        make_img(3, q);
        wr_q.delete();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        send_bytes(q, 12, 0, -1);
        chk("arst_pre_writes", wr_q.size(), 2);
        #2 reset = 1'b1;
        #1;
        chk("arst_rdy", in_ready, 1'b0);
        chk("arst_we", we, 1'b0);
        chk("arst_busy", busy, 1'b0);
        chk("arst_state", {done, err, word_count, wa, wd}, 64'h0);
        @(negedge clk);
        #2 reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = 8'($urandom);
        end
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        chk("arst_post_writes", wr_q.size(), 2);
        chk("arst_post_busy", busy, 1'b0);
        chk("arst_post_rdy", in_ready, 1'b0);

        chk("rdy_tracks_busy", rdy_viol, 0);

        $display("%0d/%0d checks passed", n_pass, n_check);
        $finish;
    end

endmodule
